// File: rtl/scr1_tcm_dpram.sv
// ---------------------------------------------------------------------------
// scr1_tcm_dpram
//   Dual-port synchronous TCM RAM. Port A is read-only (imem side), port B is
//   read/write with byte enables (dmem side). Features a configurable read
//   latency (1 or 2), byte-merged read-during-write forwarding from port B to
//   both read ports, and a post-reset clear sequencer that zeroes every word.
//
// Ports:
//   clk        - clock, all logic on rising edge
//   rst        - asynchronous active-high reset
//   rena       - port A read request
//   addra      - port A word address
//   qa         - port A read data (holds when no read completes)
//   qa_vld     - one-cycle pulse when qa is updated
//   renb       - port B read request
//   wenb       - port B write request
//   webb       - port B byte write enables
//   addrb      - port B word address
//   datab      - port B write data
//   qb         - port B read data (holds when no read completes)
//   qb_vld     - one-cycle pulse when qb is updated
//   init_busy  - clear sweep in progress; all requests ignored while high
// ---------------------------------------------------------------------------
module scr1_tcm_dpram #(
  parameter int SCR1_WIDTH   = 32,
  parameter int SCR1_SIZE    = 65536,
  parameter int SCR1_NBYTES  = SCR1_WIDTH / 8,
  parameter int RD_LATENCY   = 1,
  parameter int RDW_FWD      = 1,
  parameter int CLEAR_ON_RST = 1,
  localparam int WORDS       = SCR1_SIZE / SCR1_NBYTES,
  localparam int AW          = $clog2(WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rena,
  input  logic [AW-1:0]          addra,
  output logic [SCR1_WIDTH-1:0]  qa,
  output logic                   qa_vld,
  input  logic                   renb,
  input  logic                   wenb,
  input  logic [SCR1_NBYTES-1:0] webb,
  input  logic [AW-1:0]          addrb,
  input  logic [SCR1_WIDTH-1:0]  datab,
  output logic [SCR1_WIDTH-1:0]  qb,
  output logic                   qb_vld,
  output logic                   init_busy
);

  // Reject illegal configurations while elaborating
  generate
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
      $error("scr1_tcm_dpram: RD_LATENCY must be 1 or 2");
    end
    if ((SCR1_WIDTH % 8) != 0) begin : g_bad_width
      $error("scr1_tcm_dpram: SCR1_WIDTH must be a multiple of 8");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Replace the bytes selected by i_be with the corresponding bytes of i_new
  function automatic logic [SCR1_WIDTH-1:0] f_byte_merge(
    input logic [SCR1_WIDTH-1:0]  i_old,
    input logic [SCR1_WIDTH-1:0]  i_new,
    input logic [SCR1_NBYTES-1:0] i_be
  );
    logic [SCR1_WIDTH-1:0] v_word;
    v_word = i_old;
    for (int i = 0; i < SCR1_NBYTES; i++) begin
      if (i_be[i]) begin
        v_word[8*i +: 8] = i_new[8*i +: 8];
      end else begin
        v_word[8*i +: 8] = i_old[8*i +: 8];
      end
    end
    return v_word;
  endfunction

  logic [SCR1_WIDTH-1:0]  r_mem [WORDS];
  state_t                 r_state;
  logic [AW-1:0]          r_clr_cnt;
  logic                   r_init_busy;
  logic [SCR1_WIDTH-1:0]  r_qa1;
  logic                   r_qa1_vld;
  logic [SCR1_WIDTH-1:0]  r_qb1;
  logic                   r_qb1_vld;

  logic                   w_ready;
  logic                   w_rd_a;
  logic                   w_rd_b;
  logic                   w_wr_b;
  logic                   w_clr_we;
  logic [SCR1_NBYTES-1:0] w_fwd_be_a;
  logic [SCR1_NBYTES-1:0] w_fwd_be_b;
  logic [SCR1_WIDTH-1:0]  w_rdata_a;
  logic [SCR1_WIDTH-1:0]  w_rdata_b;

  // Request qualification and read-during-write forwarding masks
  always_comb begin
    w_ready    = (r_state == ST_READY);
    w_rd_a     = rena & w_ready;
    w_rd_b     = renb & w_ready;
    // rst gating keeps the array untouched while reset is held
    w_wr_b     = wenb & w_ready & ~rst;
    w_clr_we   = (r_state == ST_CLEAR) & ~rst;
    w_fwd_be_a = {SCR1_NBYTES{1'b0}};
    w_fwd_be_b = {SCR1_NBYTES{1'b0}};
    if ((RDW_FWD != 0) && w_wr_b) begin
      // Port B always reads its own write address; port A only on a match
      w_fwd_be_b = webb;
      if (addra == addrb) begin
        w_fwd_be_a = webb;
      end else begin
        w_fwd_be_a = {SCR1_NBYTES{1'b0}};
      end
    end else begin
      w_fwd_be_a = {SCR1_NBYTES{1'b0}};
      w_fwd_be_b = {SCR1_NBYTES{1'b0}};
    end
    w_rdata_a = f_byte_merge(r_mem[addra], datab, w_fwd_be_a);
    w_rdata_b = f_byte_merge(r_mem[addrb], datab, w_fwd_be_b);
  end

  // Array write port: clear sweep or byte-enabled port B write
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= {SCR1_WIDTH{1'b0}};
    end else if (w_wr_b) begin
      for (int i = 0; i < SCR1_NBYTES; i++) begin
        if (webb[i]) begin
          r_mem[addrb][8*i +: 8] <= datab[8*i +: 8];
        end
      end
    end
  end

  // Clear sequencer: one word per cycle, READY on the edge that writes the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      r_clr_cnt   <= {AW{1'b0}};
      r_init_busy <= (CLEAR_ON_RST != 0) ? 1'b1 : 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
          if (r_clr_cnt == AW'(WORDS - 1)) begin
            r_state     <= ST_READY;
            r_init_busy <= 1'b0;
          end
        end
        ST_READY: begin
          r_init_busy <= 1'b0;
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clr_cnt   <= {AW{1'b0}};
          r_init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Read stage 1: capture array word (or merged word) on an accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qa1     <= {SCR1_WIDTH{1'b0}};
      r_qa1_vld <= 1'b0;
      r_qb1     <= {SCR1_WIDTH{1'b0}};
      r_qb1_vld <= 1'b0;
    end else begin
      r_qa1_vld <= w_rd_a;
      r_qb1_vld <= w_rd_b;
      if (w_rd_a) begin
        r_qa1 <= w_rdata_a;
      end
      if (w_rd_b) begin
        r_qb1 <= w_rdata_b;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [SCR1_WIDTH-1:0] r_qa2;
      logic                  r_qa2_vld;
      logic [SCR1_WIDTH-1:0] r_qb2;
      logic                  r_qb2_vld;

      // Read stage 2: output register, loads only when stage 1 completed a read
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_qa2     <= {SCR1_WIDTH{1'b0}};
          r_qa2_vld <= 1'b0;
          r_qb2     <= {SCR1_WIDTH{1'b0}};
          r_qb2_vld <= 1'b0;
        end else begin
          r_qa2_vld <= r_qa1_vld;
          r_qb2_vld <= r_qb1_vld;
          if (r_qa1_vld) begin
            r_qa2 <= r_qa1;
          end
          if (r_qb1_vld) begin
            r_qb2 <= r_qb1;
          end
        end
      end

      assign qa     = r_qa2;
      assign qa_vld = r_qa2_vld;
      assign qb     = r_qb2;
      assign qb_vld = r_qb2_vld;
    end else begin : g_lat1
      assign qa     = r_qa1;
      assign qa_vld = r_qa1_vld;
      assign qb     = r_qb1;
      assign qb_vld = r_qb1_vld;
    end
  endgenerate

  assign init_busy = r_init_busy;

endmodule

// File: tb/tb_scr1_tcm_dpram.sv
// ---------------------------------------------------------------------------
// tb_scr1_tcm_dpram
//   Directed bench for scr1_tcm_dpram with 16-word arrays. Three instances
//   share one stimulus bus:
//     u_dut : RD_LATENCY=1, RDW_FWD=1, CLEAR_ON_RST=1 (table-driven checks)
//     u_l2  : RD_LATENCY=2, RDW_FWD=0, CLEAR_ON_RST=1
//     u_nc  : RD_LATENCY=1, RDW_FWD=1, CLEAR_ON_RST=0
//   Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_scr1_tcm_dpram;

  logic        clk;
  logic        rst;
  logic        rena;
  logic [3:0]  addra;
  logic        renb;
  logic        wenb;
  logic [3:0]  webb;
  logic [3:0]  addrb;
  logic [31:0] datab;

  logic [31:0] qa1, qb1, qa2, qb2, qa_nc, qb_nc;
  logic        qa_vld1, qb_vld1, qa_vld2, qb_vld2, qa_vld_nc, qb_vld_nc;
  logic        busy1, busy2, busy_nc;

  int checks = 0;
  int errors = 0;

  scr1_tcm_dpram #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .RD_LATENCY(1), .RDW_FWD(1), .CLEAR_ON_RST(1)) u_dut (
    .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa1), .qa_vld(qa_vld1),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb1), .qb_vld(qb_vld1), .init_busy(busy1));

  scr1_tcm_dpram #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .RD_LATENCY(2), .RDW_FWD(0), .CLEAR_ON_RST(1)) u_l2 (
    .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa2), .qa_vld(qa_vld2),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb2), .qb_vld(qb_vld2), .init_busy(busy2));

  scr1_tcm_dpram #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .RD_LATENCY(1), .RDW_FWD(1), .CLEAR_ON_RST(0)) u_nc (
    .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa_nc), .qa_vld(qa_vld_nc),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb_nc), .qb_vld(qb_vld_nc), .init_busy(busy_nc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ra;
    logic [3:0]  aa;
    logic        rb;
    logic        wb;
    logic [3:0]  be;
    logic [3:0]  ab;
    logic [31:0] d;
    logic [31:0] eqa;
    logic        eqav;
    logic [31:0] eqb;
    logic        eqbv;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic ra, input logic [3:0] aa, input logic rb, input logic wb,
                              input logic [3:0] be, input logic [3:0] ab, input logic [31:0] d,
                              input logic [31:0] eqa, input logic eqav,
                              input logic [31:0] eqb, input logic eqbv);
    vec_t v;
    v.ra = ra; v.aa = aa; v.rb = rb; v.wb = wb; v.be = be; v.ab = ab; v.d = d;
    v.eqa = eqa; v.eqav = eqav; v.eqb = eqb; v.eqbv = eqbv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drv(input logic ra, input logic [3:0] aa, input logic rb, input logic wb,
                     input logic [3:0] be, input logic [3:0] ab, input logic [31:0] d);
    rena = ra; addra = aa; renb = rb; wenb = wb; webb = be; addrb = ab; datab = d;
  endtask

  task automatic idle();
    drv(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 32'h0000_0000);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count edges from reset release (called at a falling edge) until init_busy drops
  task automatic sweep_count(output int edges);
    edges = 0;
    while (busy1 && edges < 100) begin
      cyc();
      edges++;
    end
  endtask

  int  edges;
  bit  vld_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table for the lat1/fwd1 instance, applied right after the first sweep
    tbl[0]  = mk(1, 4'd2, 1, 0, 4'b0000, 4'd2, 32'h0,        32'h0000_0000, 1, 32'h0000_0000, 1);
    tbl[1]  = mk(0, 4'd0, 0, 1, 4'b1111, 4'd3, 32'h11223344, 32'h0000_0000, 0, 32'h0000_0000, 0);
    tbl[2]  = mk(0, 4'd0, 0, 1, 4'b0101, 4'd3, 32'hAABBCCDD, 32'h0000_0000, 0, 32'h0000_0000, 0);
    tbl[3]  = mk(1, 4'd3, 0, 0, 4'b0000, 4'd0, 32'h0,        32'h11BB_33DD, 1, 32'h0000_0000, 0);
    tbl[4]  = mk(0, 4'd0, 0, 1, 4'b1111, 4'd5, 32'h01020304, 32'h11BB_33DD, 0, 32'h0000_0000, 0);
    tbl[5]  = mk(1, 4'd5, 1, 1, 4'b0011, 4'd5, 32'hFFFFEEEE, 32'h0102_EEEE, 1, 32'h0102_EEEE, 1);
    tbl[6]  = mk(1, 4'd5, 1, 0, 4'b0000, 4'd5, 32'h0,        32'h0102_EEEE, 1, 32'h0102_EEEE, 1);
    tbl[7]  = mk(0, 4'd0, 1, 1, 4'b0000, 4'd3, 32'h0,        32'h0102_EEEE, 0, 32'h11BB_33DD, 1);
    tbl[8]  = mk(1, 4'd3, 0, 0, 4'b0000, 4'd0, 32'h0,        32'h11BB_33DD, 1, 32'h11BB_33DD, 0);
    tbl[9]  = mk(1, 4'd5, 0, 1, 4'b1000, 4'd5, 32'hAA000000, 32'hAA02_EEEE, 1, 32'h11BB_33DD, 0);
    tbl[10] = mk(0, 4'd0, 0, 1, 4'b1111, 4'd0, 32'd10,       32'hAA02_EEEE, 0, 32'h11BB_33DD, 0);
    tbl[11] = mk(0, 4'd0, 0, 1, 4'b1111, 4'd1, 32'd11,       32'hAA02_EEEE, 0, 32'h11BB_33DD, 0);
    tbl[12] = mk(0, 4'd0, 0, 1, 4'b1111, 4'd2, 32'd12,       32'hAA02_EEEE, 0, 32'h11BB_33DD, 0);

    // Reset state
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_qa", qa1, 32'h0);
    chk("rst_qa_vld", {31'd0, qa_vld1}, 32'h0);
    chk("rst_qb", qb1, 32'h0);
    chk("rst_busy", {31'd0, busy1}, 32'h1);
    chk("rst_busy_l2", {31'd0, busy2}, 32'h1);
    chk("rst_busy_noclr", {31'd0, busy_nc}, 32'h0);

    // First sweep, with a write+read to word 2 issued while busy
    rst = 1'b0;
    edges = 0;
    vld_seen = 1'b0;
    while (busy1 && edges < 100) begin
      if (edges == 3) drv(1'b1, 4'd2, 1'b1, 1'b1, 4'b1111, 4'd2, 32'hDEADBEEF);
      else idle();
      cyc();
      edges++;
      if (qa_vld1 || qb_vld1 || qa_vld2 || qb_vld2) vld_seen = 1'b1;
      if (edges == 4) begin
        chk("noclr_fwd_qb", qb_nc, 32'hDEADBEEF);
        chk("noclr_qb_vld", {31'd0, qb_vld_nc}, 32'h1);
      end
    end
    idle();
    chk("sweep1_len", edges, 16);
    chk("busy_vld_seen", {31'd0, vld_seen}, 32'h0);
    chk("sweep1_l2_busy", {31'd0, busy2}, 32'h0);

    // Table-driven single-cycle vectors on the lat1/fwd1 instance
    for (int i = 0; i < 13; i++) begin
      drv(tbl[i].ra, tbl[i].aa, tbl[i].rb, tbl[i].wb, tbl[i].be, tbl[i].ab, tbl[i].d);
      cyc();
      chk($sformatf("vec%0d_qa", i), qa1, tbl[i].eqa);
      chk($sformatf("vec%0d_qa_vld", i), {31'd0, qa_vld1}, {31'd0, tbl[i].eqav});
      chk($sformatf("vec%0d_qb", i), qb1, tbl[i].eqb);
      chk($sformatf("vec%0d_qb_vld", i), {31'd0, qb_vld1}, {31'd0, tbl[i].eqbv});
    end
    idle();

    // Read-during-write with old-data policy on the lat2 instance
    drv(1'b0, 4'd0, 1'b0, 1'b1, 4'b1111, 4'd6, 32'h01020304);
    cyc();
    drv(1'b1, 4'd6, 1'b1, 1'b1, 4'b0011, 4'd6, 32'hFFFFEEEE);
    cyc();
    chk("rdw_fwd1_qa", qa1, 32'h0102EEEE);
    chk("rdw_fwd1_qb", qb1, 32'h0102EEEE);
    chk("l2_not_yet_vld", {31'd0, qa_vld2}, 32'h0);
    idle();
    cyc();
    chk("rdw_fwd0_qa", qa2, 32'h01020304);
    chk("rdw_fwd0_qb", qb2, 32'h01020304);
    chk("rdw_fwd0_qa_vld", {31'd0, qa_vld2}, 32'h1);
    chk("rdw_fwd0_qb_vld", {31'd0, qb_vld2}, 32'h1);
    drv(1'b1, 4'd6, 1'b0, 1'b0, 4'b0000, 4'd0, 32'h0);
    cyc();
    idle();
    cyc();
    chk("l2_later_read", qa2, 32'h0102EEEE);

    // Pipelined back-to-back reads with latency 2
    drv(1'b1, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 32'h0);
    cyc();
    chk("pipe_e0_qa", qa2, 32'h0102EEEE);
    chk("pipe_e0_vld", {31'd0, qa_vld2}, 32'h0);
    drv(1'b1, 4'd1, 1'b0, 1'b0, 4'b0000, 4'd0, 32'h0);
    cyc();
    chk("pipe_e1_qa", qa2, 32'd10);
    chk("pipe_e1_vld", {31'd0, qa_vld2}, 32'h1);
    drv(1'b1, 4'd2, 1'b0, 1'b0, 4'b0000, 4'd0, 32'h0);
    cyc();
    chk("pipe_e2_qa", qa2, 32'd11);
    chk("pipe_e2_vld", {31'd0, qa_vld2}, 32'h1);
    idle();
    cyc();
    chk("pipe_e3_qa", qa2, 32'd12);
    chk("pipe_e3_vld", {31'd0, qa_vld2}, 32'h1);
    cyc();
    chk("pipe_e4_qa", qa2, 32'd12);
    chk("pipe_e4_vld", {31'd0, qa_vld2}, 32'h0);

    // Preload all ones, reset, and confirm the sweep zeroes everything
    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 4'd0, 1'b0, 1'b1, 4'b1111, 4'(i), 32'hFFFFFFFF);
      cyc();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_qa", qa1, 32'h0);
    chk("async_rst_qa_l2", qa2, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    sweep_count(edges);
    chk("sweep2_len", edges, 16);
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 4'(i), 1'b1, 1'b0, 4'b0000, 4'(15 - i), 32'h0);
      cyc();
      chk($sformatf("clr_qa_w%0d", i), qa1, 32'h0);
      chk($sformatf("clr_qb_w%0d", 15 - i), qb1, 32'h0);
      chk($sformatf("clr_vld_w%0d", i), {31'd0, qa_vld1}, 32'h1);
    end
    idle();

    // Reset asserted part-way through a sweep restarts it from word 0
    drv(1'b0, 4'd0, 1'b0, 1'b1, 4'b1111, 4'd4, 32'h5A5A5A5A);
    cyc();
    drv(1'b1, 4'd4, 1'b0, 1'b0, 4'b0000, 4'd0, 32'h0);
    cyc();
    chk("w4_qa", qa1, 32'h5A5A5A5A);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_ready_qa", qa1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (7) cyc();
    chk("mid_sweep_busy", {31'd0, busy1}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy1}, 32'h1);
    chk("mid_rst_qa", qa1, 32'h0);
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    sweep_count(edges);
    chk("sweep3_len", edges, 16);
    drv(1'b1, 4'd4, 1'b0, 1'b0, 4'b0000, 4'd0, 32'h0);
    cyc();
    chk("w4_cleared", qa1, 32'h0);
    chk("w4_cleared_vld", {31'd0, qa_vld1}, 32'h1);
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
